axis_frame_sink: RTL and testbench

AXI4-Stream video sink that terminates the pixel stream produced by the fractal stream generators, with one 32-bit pixel per beat. It accepts beats under optional pseudo-random backpressure and tracks raster position. It checks frame framing: tuser marks start of frame and tlast marks end of frame. For each frame it reports a registered per-frame status and a pixel checksum. It is used as the stream endpoint in simulation benches and as an on-chip link monitor ahead of the video DMA.

---
 rtl/axis_frame_sink.sv | 218 +++++++++++++++++++++
 tb/tb_axis_frame_sink.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_sink.sv
// AXI4-Stream video sink: accepts one 32-bit pixel per beat, checks SOF/EOF framing against the
// raster size and reports a registered per-frame status, checksum and running frame counters.
`timescale 1ns / 1ps

module axis_frame_sink #(
    parameter int unsigned X_SIZE     = 640,
    parameter int unsigned Y_SIZE     = 480,
    parameter int unsigned READY_MODE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    input  logic        in_stream_tuser,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [3:0]  frame_err,
    output logic [31:0] frame_checksum,
    output logic [15:0] good_frames,
    output logic [15:0] err_frames,
    output logic [15:0] dropped_beats
);

    localparam logic [9:0] XLast     = 10'(X_SIZE - 1);
    localparam logic [8:0] YLast     = 9'(Y_SIZE - 1);
    localparam bit         SinglePix = (X_SIZE == 1) && (Y_SIZE == 1);

    localparam logic [3:0] ErrKeep        = 4'b1000;
    localparam logic [3:0] ErrEarlySof    = 4'b0100;
    localparam logic [3:0] ErrEarlyLast   = 4'b0010;
    localparam logic [3:0] ErrMissingLast = 4'b0001;

    typedef enum logic {StWaitSof, StInFrame} state_e;

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [31:0] sum_q, sum_d;
    logic [3:0]  err_q, err_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [3:0]  ferr_q, ferr_d;
    logic [31:0] fsum_q, fsum_d;
    logic [15:0] good_q, good_d;
    logic [15:0] errc_q, errc_d;
    logic [15:0] drop_q, drop_d;

    logic        accept, last_pos, sof_term, abort_discard;
    logic [31:0] beat_val, cur_sum, rep_sum;
    logic [3:0]  keep_err, cur_err, sof_err, rep_err;
    logic        report;
    logic        unused_pad;

    assign unused_pad = ^in_stream_tdata[7:0];

    always_comb begin
        accept        = in_stream_tvalid & tready_q;
        last_pos      = (x_q == XLast) && (y_q == YLast);
        keep_err      = (in_stream_tkeep != 4'hF) ? ErrKeep : 4'b0000;
        beat_val      = {8'h00, in_stream_tdata[31:8]};
        sof_term      = in_stream_tlast | SinglePix;
        // SOF+EOF while a frame is open: only the aborted frame is reported
        abort_discard = (state_q == StInFrame) & in_stream_tuser & in_stream_tlast;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_stream_tuser) begin
                state_d = sof_term ? StWaitSof : StInFrame;
            end else if ((state_q == StInFrame) && (in_stream_tlast || last_pos)) begin
                state_d = StWaitSof;
            end
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        err_d   = err_q;
        drop_d  = drop_q;
        report  = 1'b0;
        rep_err = 4'b0000;
        rep_sum = 32'h0;
        cur_err = err_q | keep_err;
        cur_sum = sum_q + beat_val;
        sof_err = keep_err;
        if (in_stream_tlast && !SinglePix) begin
            sof_err = sof_err | ErrEarlyLast;
        end else if (!in_stream_tlast && SinglePix) begin
            sof_err = sof_err | ErrMissingLast;
        end

        if (accept) begin
            if (in_stream_tuser) begin
                if (state_q == StInFrame) begin
                    report  = 1'b1;
                    rep_err = err_q | ErrEarlySof | (abort_discard ? ErrEarlyLast : 4'b0000);
                    rep_sum = sum_q;
                end
                if (abort_discard) begin
                    x_d = 10'd0;
                    y_d = 9'd0;
                end else if (sof_term) begin
                    report  = 1'b1;
                    rep_err = sof_err;
                    rep_sum = beat_val;
                    x_d     = 10'd0;
                    y_d     = 9'd0;
                end else begin
                    // SOF beat sits at (0,0); hold the position of the next beat
                    sum_d = beat_val;
                    err_d = sof_err;
                    x_d   = (XLast == 10'd0) ? 10'd0 : 10'd1;
                    y_d   = (XLast == 10'd0) ? 9'd1 : 9'd0;
                end
            end else if (state_q == StWaitSof) begin
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end else if (in_stream_tlast || last_pos) begin
                report  = 1'b1;
                rep_sum = cur_sum;
                rep_err = cur_err | (in_stream_tlast ? (last_pos ? 4'b0000 : ErrEarlyLast)
                                                     : ErrMissingLast);
                x_d     = 10'd0;
                y_d     = 9'd0;
            end else begin
                sum_d = cur_sum;
                err_d = cur_err;
                if (x_q == XLast) begin
                    x_d = 10'd0;
                    y_d = y_q + 9'd1;
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
        end
    end

    always_comb begin
        done_d = report;
        ok_d   = ok_q;
        ferr_d = ferr_q;
        fsum_d = fsum_q;
        good_d = good_q;
        errc_d = errc_q;
        if (report) begin
            ok_d   = (rep_err == 4'b0000);
            ferr_d = rep_err;
            fsum_d = rep_sum;
            if (rep_err == 4'b0000) begin
                good_d = good_q + 16'd1;
            end else if (errc_q != 16'hFFFF) begin
                errc_d = errc_q + 16'd1;
            end
        end
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        tready_d = (READY_MODE == 0) ? 1'b1 : (lfsr_q[0] | lfsr_q[1]);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q      <= 10'd0;
            y_q      <= 9'd0;
            sum_q    <= 32'h0;
            err_q    <= 4'b0000;
            lfsr_q   <= LFSR_SEED;
            tready_q <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            ferr_q   <= 4'b0000;
            fsum_q   <= 32'h0;
            good_q   <= 16'h0;
            errc_q   <= 16'h0;
            drop_q   <= 16'h0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            sum_q    <= sum_d;
            err_q    <= err_d;
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            ferr_q   <= ferr_d;
            fsum_q   <= fsum_d;
            good_q   <= good_d;
            errc_q   <= errc_d;
            drop_q   <= drop_d;
        end
    end

    assign in_stream_tready = tready_q;
    assign frame_done       = done_q;
    assign frame_ok         = ok_q;
    assign frame_err        = ferr_q;
    assign frame_checksum   = fsum_q;
    assign good_frames      = good_q;
    assign err_frames       = errc_q;
    assign dropped_beats    = drop_q;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Scoreboard bench: two sinks (always-ready and LFSR backpressure) driven by directed and random
// frames; a beat-index reference model queues expected reports, a monitor pops them on frame_done.
`timescale 1ns / 1ps

module tb_axis_frame_sink;

    localparam int XS   = 4;
    localparam int YS   = 3;
    localparam int NPIX = XS * YS;

    typedef struct packed {
        logic [3:0]  err;
        logic [31:0] sum;
        logic [15:0] good;
        logic [15:0] errc;
        logic [15:0] drop;
    } rpt_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata  [2];
    logic [3:0]  tkeep  [2];
    logic        tlast  [2];
    logic        tvalid [2];
    logic        tuser  [2];
    logic        tready [2];
    logic        done   [2];
    logic        ok     [2];
    logic [3:0]  ferr   [2];
    logic [31:0] fsum   [2];
    logic [15:0] good   [2];
    logic [15:0] errc   [2];
    logic [15:0] drop   [2];

    int checks = 0;
    int errors = 0;
    int low_seen = 0;
    logic armed;

    // reference model state, indexed by DUT
    bit          m_in   [2];
    int          m_idx  [2];
    logic [31:0] m_sum  [2];
    logic [3:0]  m_err  [2];
    logic [15:0] m_good [2];
    logic [15:0] m_errc [2];
    logic [15:0] m_drop [2];
    rpt_t        q0[$];
    rpt_t        q1[$];

    logic [3:0]  last_err [2] = '{4'b0, 4'b0};
    logic [31:0] last_sum [2] = '{32'h0, 32'h0};
    logic        last_ok  [2] = '{1'b0, 1'b0};

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_frame_sink #(
            .X_SIZE     (XS),
            .Y_SIZE     (YS),
            .READY_MODE (g),
            .LFSR_SEED  (16'hACE1)
        ) u_dut (
            .aclk             (aclk),
            .aresetn          (aresetn),
            .in_stream_tdata  (tdata[g]),
            .in_stream_tkeep  (tkeep[g]),
            .in_stream_tlast  (tlast[g]),
            .in_stream_tvalid (tvalid[g]),
            .in_stream_tready (tready[g]),
            .in_stream_tuser  (tuser[g]),
            .frame_done       (done[g]),
            .frame_ok         (ok[g]),
            .frame_err        (ferr[g]),
            .frame_checksum   (fsum[g]),
            .good_frames      (good[g]),
            .err_frames       (errc[g]),
            .dropped_beats    (drop[g])
        );
    end

    task automatic chk(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic push_report(input int d, input logic [3:0] e, input logic [31:0] s);
        rpt_t r;
        if (e == 4'b0) m_good[d] = m_good[d] + 16'd1;
        else if (m_errc[d] != 16'hFFFF) m_errc[d] = m_errc[d] + 16'd1;
        r = '{err: e, sum: s, good: m_good[d], errc: m_errc[d], drop: m_drop[d]};
        if (d == 0) q0.push_back(r);
        else q1.push_back(r);
        m_in[d] = 1'b0;
    endtask

    // Frame ends on tlast or on its NPIX-th pixel, whichever comes first.
    task automatic end_or_advance(input int d, input bit l);
        if (l && m_idx[d] != NPIX - 1) push_report(d, m_err[d] | 4'b0010, m_sum[d]);
        else if (m_idx[d] == NPIX - 1) push_report(d, m_err[d] | (l ? 4'b0000 : 4'b0001), m_sum[d]);
        else m_idx[d]++;
    endtask

    task automatic model_beat(input int d, input bit u, input bit l, input logic [3:0] k,
                              input logic [31:0] t);
        logic [3:0]  kb;
        logic [31:0] v;
        bool_discard: begin end
        kb = (k != 4'hF) ? 4'b1000 : 4'b0000;
        v  = {8'h00, t[31:8]};
        if (u) begin
            if (m_in[d] && l && NPIX > 1) begin
                push_report(d, m_err[d] | 4'b0110, m_sum[d]);
            end else begin
                if (m_in[d]) push_report(d, m_err[d] | 4'b0100, m_sum[d]);
                m_in[d]  = 1'b1;
                m_idx[d] = 0;
                m_err[d] = kb;
                m_sum[d] = v;
                end_or_advance(d, l);
            end
        end else if (!m_in[d]) begin
            if (m_drop[d] != 16'hFFFF) m_drop[d] = m_drop[d] + 16'd1;
        end else begin
            m_err[d] = m_err[d] | kb;
            m_sum[d] = m_sum[d] + v;
            end_or_advance(d, l);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_in[d]   = 1'b0;
            m_idx[d]  = 0;
            m_err[d]  = 4'b0;
            m_sum[d]  = 32'h0;
            m_good[d] = 16'h0;
            m_errc[d] = 16'h0;
            m_drop[d] = 16'h0;
        end
    endtask

    task automatic send_beat(input int d, input bit u, input bit l, input logic [3:0] k,
                             input logic [31:0] t);
        bit acc;
        int waitc;
        acc   = 1'b0;
        waitc = 0;
        @(negedge aclk);
        tvalid[d] = 1'b1;
        tuser[d]  = u;
        tlast[d]  = l;
        tkeep[d]  = k;
        tdata[d]  = t;
        while (!acc && waitc < 200) begin
            acc = tready[d];
            @(posedge aclk);
            if (!acc) begin
                waitc++;
                @(negedge aclk);
            end
        end
        if (acc) model_beat(d, u, l, k, t);
        else chk("accept_timeout", d, 64'(acc), 64'd1);
    endtask

    task automatic idle(input int d, input int n);
        @(negedge aclk);
        tvalid[d] = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic send_seq(input int d, input int n, input int s1, input int s2, input int la,
                            input int bk, input bit rnd);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            t = rnd ? $urandom : {i[23:0], 8'h00};
            send_beat(d, (i == s1) || (i == s2), i == la, (i == bk) ? 4'h7 : 4'hF, t);
        end
    endtask

    task automatic directed_suite(input int d);
        send_seq(d, 12, 0, -1, 11, -1, 1'b0);
        idle(d, 2);
        chk("clean_good", d, good[d], 1);
        chk("clean_sum", d, fsum[d], 32'h42);
        chk("clean_err", d, ferr[d], 0);
        chk("clean_ok", d, ok[d], 1);
        for (int r = 0; r < 3; r++) send_seq(d, 12, 0, -1, 11, -1, 1'b0);
        idle(d, 2);
        chk("b2b_good", d, good[d], 4);
        chk("b2b_sum", d, fsum[d], 32'h42);
        send_seq(d, 5, -1, -1, -1, -1, 1'b0);
        send_seq(d, 12, 0, -1, 11, -1, 1'b0);
        idle(d, 2);
        chk("nosof_drop", d, drop[d], 5);
        chk("nosof_good", d, good[d], 5);
        send_seq(d, 8, 0, -1, 7, -1, 1'b0);
        idle(d, 2);
        chk("early_last_err", d, ferr[d], 4'b0010);
        chk("early_last_cnt", d, errc[d], 1);
        send_seq(d, 12, 0, -1, 11, -1, 1'b0);
        idle(d, 2);
        chk("after_early_ok", d, ok[d], 1);
        send_seq(d, 18, 0, 6, 17, -1, 1'b0);
        idle(d, 2);
        chk("early_sof_new_ok", d, ok[d], 1);
        chk("early_sof_cnt", d, errc[d], 2);
        send_seq(d, 12, 0, -1, 11, 3, 1'b0);
        idle(d, 2);
        chk("keep_err", d, ferr[d], 4'b1000);
        send_seq(d, 12, 0, -1, -1, -1, 1'b0);
        idle(d, 2);
        chk("missing_last", d, ferr[d], 4'b0001);
        send_seq(d, 5, 0, 3, 3, -1, 1'b0);
        idle(d, 2);
        chk("sof_last_abort", d, ferr[d], 4'b0110);
        chk("sof_last_drop", d, drop[d], 6);
        send_seq(d, 1, 0, -1, 0, -1, 1'b0);
        idle(d, 2);
        chk("sof_last_idle", d, ferr[d], 4'b0010);
        chk("sof_last_cnt", d, errc[d], 6);
    endtask

    task automatic rand_suite(input int d);
        int kind, n, s1, s2, la, bk;
        for (int f = 0; f < 40; f++) begin
            kind = int'($urandom_range(0, 7));
            s1 = 0;
            s2 = -1;
            la = 11;
            n  = 12;
            case (kind)
                0: begin s1 = -1; la = -1; n = int'($urandom_range(1, 4)); end
                1: begin s2 = int'($urandom_range(1, 10)); la = s2 + 11; n = la + 1; end
                2: begin la = int'($urandom_range(0, 10)); n = la + 1; end
                3: la = -1;
                4: begin s2 = int'($urandom_range(1, 10)); la = s2; n = la + 1; end
                default: ;
            endcase
            bk = -1;
            if ($urandom_range(0, 4) == 0) bk = int'($urandom_range(0, n - 1));
            send_seq(d, n, s1, s2, la, bk, 1'b1);
            if ($urandom_range(0, 2) == 0) idle(d, int'($urandom_range(1, 3)));
        end
        idle(d, 2);
    endtask

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) armed <= 1'b0;
        else armed <= 1'b1;
    end

    always @(negedge aclk) begin
        rpt_t e;
        bit   empty;
        for (int d = 0; d < 2; d++) begin
            if (!aresetn) begin
                chk("rst_flags", d, {tready[d], done[d], ok[d], ferr[d]}, 0);
                chk("rst_sum", d, fsum[d], 0);
                chk("rst_cnt", d, {good[d], errc[d], drop[d]}, 0);
                last_err[d] = 4'b0;
                last_sum[d] = 32'h0;
                last_ok[d]  = 1'b0;
            end else if (done[d]) begin
                empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (empty) begin
                    chk("spurious_done", d, 1, 0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("rpt_ok", d, ok[d], (e.err == 4'b0) ? 1 : 0);
                    chk("rpt_err", d, ferr[d], e.err);
                    chk("rpt_sum", d, fsum[d], e.sum);
                    chk("rpt_cnt", d, {good[d], errc[d], drop[d]}, {e.good, e.errc, e.drop});
                    last_err[d] = e.err;
                    last_sum[d] = e.sum;
                    last_ok[d]  = (e.err == 4'b0);
                end
            end else begin
                chk("hold_status", d, {ok[d], ferr[d], fsum[d]},
                    {last_ok[d], last_err[d], last_sum[d]});
            end
        end
        if (armed) chk("mode0_ready", 0, tready[0], 1);
        if (armed && !tready[1]) low_seen++;
    end

    task automatic release_reset();
        @(posedge aclk);
        #2 aresetn = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            tvalid[d] = 1'b0;
            tuser[d]  = 1'b0;
            tlast[d]  = 1'b0;
            tkeep[d]  = 4'hF;
            tdata[d]  = 32'h0;
        end
        model_reset();
        repeat (3) @(posedge aclk);
        release_reset();
        fork
            begin directed_suite(0); rand_suite(0); end
            begin directed_suite(1); rand_suite(1); end
        join
        chk("q0_drained", 0, q0.size(), 0);
        chk("q1_drained", 1, q1.size(), 0);
        for (int d = 0; d < 2; d++) begin
            chk("final_cnt", d, {good[d], errc[d], drop[d]}, {m_good[d], m_errc[d], m_drop[d]});
        end
        chk("mode1_ready_low", 1, 64'(low_seen != 0), 1);

        fork
            send_seq(0, 6, 0, -1, -1, -1, 1'b0);
            send_seq(1, 6, 0, -1, -1, -1, 1'b0);
        join
        @(posedge aclk);
        #2 aresetn = 1'b0;
        tvalid[0] = 1'b0;
        tvalid[1] = 1'b0;
        model_reset();
        q0.delete();
        q1.delete();
        repeat (3) @(negedge aclk);
        release_reset();
        fork
            begin send_seq(0, 12, 0, -1, 11, -1, 1'b0); idle(0, 2); end
            begin send_seq(1, 12, 0, -1, 11, -1, 1'b0); idle(1, 2); end
        join
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_good", d, {good[d], errc[d], drop[d]}, {16'd1, 16'd0, 16'd0});
            chk("post_rst_ok", d, ok[d], 1);
            chk("post_rst_sum", d, fsum[d], 32'h42);
        end
        chk("post_rst_q0", 0, q0.size(), 0);
        chk("post_rst_q1", 1, q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
